// File: rtl/fifo_blk_pkg.sv
// Shared types for the block-FIFO scheduler: owner FSM states and error flag bits.
// The watchdog is built only when FIFO_BLK_SCHED_WDOG_EN is defined.
package fifo_blk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } own_state_e;

    localparam int ERR_COMMIT  = 0;
    localparam int ERR_RELEASE = 1;
    localparam int ERR_P_WDOG  = 2;
    localparam int ERR_C_WDOG  = 3;

endpackage

// File: rtl/fifo_blk_owner.sv
// One side (producer or consumer) of the scheduler: ownership FSM, block pointer, grant pulse.
// Optional ownership watchdog under FIFO_BLK_SCHED_WDOG_EN.
module fifo_blk_owner
    import fifo_blk_pkg::*;
#(
    parameter int NBITS       = 1,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acq_i,
    input  logic             avail_i,
    input  logic             done_i,
    output logic             gnt_o,
    output logic [NBITS-1:0] blk_o,
    output logic             own_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wdog_o
);

    own_state_e       state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [NBITS-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        gnt_d   = 1'b0;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (acq_i && avail_i) begin
                    state_d = OWN;
                    gnt_d   = 1'b1;
                end
            end
            OWN: begin
                if (done_i) begin
                    state_d = IDLE;
                    ptr_d   = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign own_o  = (state_q == OWN);
    assign done_o = own_o && done_i;
    assign err_o  = !own_o && done_i;
    assign gnt_o  = gnt_q;
    assign blk_o  = ptr_q;

`ifdef FIFO_BLK_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          wd_hit;

    // wd_q counts completed OWN cycles; saturates once the limit is reached
    assign wd_hit = own_o && (wd_q == WD_MAX);

    always_comb begin
        wd_d = '0;
        if (own_o && !done_i) begin
            wd_d = wd_hit ? wd_q : wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign wdog_o = wd_hit;
`else
    assign wdog_o = 1'b0;
`endif

endmodule

// File: rtl/fifo_blk_sched.sv
// Block-FIFO scheduler top: producer/consumer owners, shared fill count, sticky error flags.
// Define FIFO_BLK_SCHED_WDOG_EN to enable the ownership watchdogs (err_flags[3:2]).
module fifo_blk_sched
    import fifo_blk_pkg::*;
#(
    parameter int NBLKS_BITS  = 1,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p_acq,
    output logic                  p_gnt,
    output logic [NBLKS_BITS-1:0] p_blk,
    input  logic                  p_commit,
    input  logic                  c_acq,
    output logic                  c_gnt,
    output logic [NBLKS_BITS-1:0] c_blk,
    input  logic                  c_release,
    output logic [NBLKS_BITS:0]   fill_cnt,
    output logic                  blk_full,
    output logic                  blk_empty,
    output logic [3:0]            err_flags,
    input  logic                  err_clr
);

    localparam logic [NBLKS_BITS:0] FULL = {1'b1, {NBLKS_BITS{1'b0}}};

    logic                p_own, p_done, p_err, p_wdog;
    logic                c_own, c_done, c_err, c_wdog;
    logic [NBLKS_BITS:0] fill_q, fill_d;
    logic [3:0]          err_q, err_d;

    fifo_blk_owner #(
        .NBITS       (NBLKS_BITS),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_prod (
        .clk     (clk),
        .rst_n   (rst_n),
        .acq_i   (p_acq),
        .avail_i (!blk_full),
        .done_i  (p_commit),
        .gnt_o   (p_gnt),
        .blk_o   (p_blk),
        .own_o   (p_own),
        .done_o  (p_done),
        .err_o   (p_err),
        .wdog_o  (p_wdog)
    );

    fifo_blk_owner #(
        .NBITS       (NBLKS_BITS),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_cons (
        .clk     (clk),
        .rst_n   (rst_n),
        .acq_i   (c_acq),
        .avail_i (!blk_empty),
        .done_i  (c_release),
        .gnt_o   (c_gnt),
        .blk_o   (c_blk),
        .own_o   (c_own),
        .done_o  (c_done),
        .err_o   (c_err),
        .wdog_o  (c_wdog)
    );

    // Grants only happen against registered fill, so fill cannot over/underflow
    always_comb begin
        fill_d = fill_q;
        if (p_done && !c_done) begin
            fill_d = fill_q + 1'b1;
        end else if (c_done && !p_done) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_comb begin
        err_d = err_clr ? 4'b0000 : err_q;
        if (p_err)  err_d[ERR_COMMIT]  = 1'b1;
        if (c_err)  err_d[ERR_RELEASE] = 1'b1;
        if (p_wdog) err_d[ERR_P_WDOG]  = 1'b1;
        if (c_wdog) err_d[ERR_C_WDOG]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            err_q  <= '0;
        end else begin
            fill_q <= fill_d;
            err_q  <= err_d;
        end
    end

    assign fill_cnt  = fill_q;
    assign blk_full  = (fill_q == FULL);
    assign blk_empty = (fill_q == '0);
    assign err_flags = err_q;

endmodule

// File: tb/tb_fifo_blk_sched.sv
// Self-checking bench for fifo_blk_sched: directed scenarios plus randomized traffic
// against a queue-free integer model of the block scheduling rules.
module tb_fifo_blk_sched;

    localparam int NB = 1;
    localparam int N  = 2 ** NB;
    localparam int W  = 8;
`ifdef FIFO_BLK_SCHED_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_acq = 1'b0, p_commit = 1'b0;
    logic          c_acq = 1'b0, c_release = 1'b0;
    logic          err_clr = 1'b0;
    logic          p_gnt, c_gnt, blk_full, blk_empty;
    logic [NB-1:0] p_blk, c_blk;
    logic [NB:0]   fill_cnt;
    logic [3:0]    err_flags;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit   m_pown, m_cown, m_pg, m_cg;
    int   m_fill, m_wp, m_rp, m_page, m_cage;
    logic [3:0] m_err;

    fifo_blk_sched #(
        .NBLKS_BITS  (NB),
        .WDOG_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_acq     (p_acq),
        .p_gnt     (p_gnt),
        .p_blk     (p_blk),
        .p_commit  (p_commit),
        .c_acq     (c_acq),
        .c_gnt     (c_gnt),
        .c_blk     (c_blk),
        .c_release (c_release),
        .fill_cnt  (fill_cnt),
        .blk_full  (blk_full),
        .blk_empty (blk_empty),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pown = 0; m_cown = 0; m_pg = 0; m_cg = 0;
        m_fill = 0; m_wp = 0; m_rp = 0; m_page = 0; m_cage = 0;
        m_err = 4'b0000;
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the edge
    task automatic step(input bit pa, input bit pc, input bit ca,
                        input bit cr, input bit clr);
        bit commit, rel, pw, cw, s0, s1;
        int old_fill;
        p_acq = pa; p_commit = pc; c_acq = ca; c_release = cr; err_clr = clr;
        old_fill = m_fill;
        commit = m_pown && pc;
        rel = m_cown && cr;
        s0 = pc && !m_pown;
        s1 = cr && !m_cown;
        pw = 0; cw = 0;
        if (m_pown) begin
            m_page++;
            if (WDOG_EN && m_page >= W) pw = 1;
        end
        if (m_cown) begin
            m_cage++;
            if (WDOG_EN && m_cage >= W) cw = 1;
        end
        m_pg = 0;
        if (!m_pown && pa && old_fill < N) begin
            m_pown = 1; m_pg = 1; m_page = 0;
        end else if (commit) begin
            m_pown = 0; m_wp = (m_wp + 1) % N; m_page = 0;
        end
        m_cg = 0;
        if (!m_cown && ca && old_fill > 0) begin
            m_cown = 1; m_cg = 1; m_cage = 0;
        end else if (rel) begin
            m_cown = 0; m_rp = (m_rp + 1) % N; m_cage = 0;
        end
        m_fill = old_fill + int'(commit) - int'(rel);
        if (clr) m_err = 4'b0000;
        m_err = m_err | {cw, pw, s1, s0};
        @(posedge clk);
        #1;
        p_acq = 0; p_commit = 0; c_acq = 0; c_release = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({p_gnt, c_gnt, p_blk, c_blk, fill_cnt, blk_full, blk_empty, err_flags}
            !== {1'b0, 1'b0, NB'(0), NB'(0), (NB+1)'(0), 1'b0, 1'b1, 4'b0}) begin
            n_bad++;
            $display("FAIL reset: got gnt=%b/%b blk=%0d/%0d fill=%0d full=%b empty=%b err=%b",
                     p_gnt, c_gnt, p_blk, c_blk, fill_cnt, blk_full, blk_empty, err_flags);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_full();
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b1 || p_blk !== NB'(0)) begin
            n_bad++;
            $display("FAIL fill_g0: p_gnt=%b p_blk=%0d want 1/0", p_gnt, p_blk);
        end
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL gnt_pulse: p_gnt=%b want 0", p_gnt);
        end
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b1 || p_blk !== NB'(1) || fill_cnt !== (NB+1)'(1)) begin
            n_bad++;
            $display("FAIL fill_g1: p_gnt=%b p_blk=%0d fill=%0d want 1/1/1",
                     p_gnt, p_blk, fill_cnt);
        end
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (fill_cnt !== (NB+1)'(2) || blk_full !== 1'b1 || blk_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL full: fill=%0d full=%b empty=%b want 2/1/0",
                     fill_cnt, blk_full, blk_empty);
        end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b0 || m_pown) begin
            n_bad++;
            $display("FAIL full_block: p_gnt=%b want 0", p_gnt);
        end
    endtask

    task automatic test_drain_wrap();
        step(1, 0, 1, 0, 0);
        n_cmp++;
        if (c_gnt !== 1'b1 || c_blk !== NB'(0) || p_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_cg: c_gnt=%b c_blk=%0d p_gnt=%b want 1/0/0",
                     c_gnt, c_blk, p_gnt);
        end
        step(1, 0, 0, 1, 0);
        n_cmp++;
        if (fill_cnt !== (NB+1)'(1) || p_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_rel: fill=%0d p_gnt=%b want 1/0", fill_cnt, p_gnt);
        end
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b1 || p_blk !== NB'(0)) begin
            n_bad++;
            $display("FAIL wrap_pg: p_gnt=%b p_blk=%0d want 1/0", p_gnt, p_blk);
        end
    endtask

    task automatic test_simul();
        step(0, 0, 1, 0, 0);
        n_cmp++;
        if (c_gnt !== 1'b1 || c_blk !== NB'(1)) begin
            n_bad++;
            $display("FAIL simul_cg: c_gnt=%b c_blk=%0d want 1/1", c_gnt, c_blk);
        end
        step(0, 1, 0, 1, 0);
        n_cmp++;
        if (fill_cnt !== (NB+1)'(1) || p_blk !== NB'(1) || c_blk !== NB'(0)) begin
            n_bad++;
            $display("FAIL simul: fill=%0d p_blk=%0d c_blk=%0d want 1/1/0",
                     fill_cnt, p_blk, c_blk);
        end
        step(1, 0, 1, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b1 || c_gnt !== 1'b1 || p_blk !== NB'(1) || c_blk !== NB'(0)) begin
            n_bad++;
            $display("FAIL simul_regrant: gnt=%b/%b blk=%0d/%0d want 1/1 1/0",
                     p_gnt, c_gnt, p_blk, c_blk);
        end
        step(0, 1, 0, 1, 0);
    endtask

    task automatic test_errors();
        step(0, 0, 0, 1, 0);
        n_cmp++;
        if (err_flags !== 4'b0010 || fill_cnt !== (NB+1)'(1)) begin
            n_bad++;
            $display("FAIL rel_err: err=%b fill=%0d want 0010/1", err_flags, fill_cnt);
        end
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (err_flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL err_clr: err=%b want 0000", err_flags);
        end
        step(0, 1, 0, 0, 1);
        n_cmp++;
        if (err_flags !== 4'b0001 || fill_cnt !== (NB+1)'(1)) begin
            n_bad++;
            $display("FAIL set_wins: err=%b fill=%0d want 0001/1", err_flags, fill_cnt);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (p_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_own: p_gnt=%b want 1", p_gnt);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({p_gnt, c_gnt, p_blk, c_blk, fill_cnt, blk_full, blk_empty, err_flags}
            !== {1'b0, 1'b0, NB'(0), NB'(0), (NB+1)'(0), 1'b0, 1'b1, 4'b0}) begin
            n_bad++;
            $display("FAIL async_reset: gnt=%b/%b blk=%0d/%0d fill=%0d empty=%b err=%b",
                     p_gnt, c_gnt, p_blk, c_blk, fill_cnt, blk_empty, err_flags);
        end
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        step(0, 1, 0, 0, 1);
        n_cmp++;
        if (fill_cnt !== (NB+1)'(0) || err_flags !== 4'b0001) begin
            n_bad++;
            $display("FAIL abandon: fill=%0d err=%b want 0/0001", fill_cnt, err_flags);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_wdog();
        logic [NB-1:0] held;
        step(1, 0, 0, 0, 0);
        held = p_blk;
        repeat (W - 1) step(0, 0, 0, 0, 0);
        n_cmp++;
        if (err_flags[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_early: err=%b want bit2=0", err_flags);
        end
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (err_flags[2] !== WDOG_EN || p_blk !== held || err_flags[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog: err=%b p_blk=%0d want bit2=%b p_blk=%0d",
                     err_flags, p_blk, WDOG_EN, held);
        end
        step(0, 1, 0, 0, 1);
        n_cmp++;
        if (fill_cnt !== (NB+1)'(m_fill) || err_flags !== m_err) begin
            n_bad++;
            $display("FAIL wdog_commit: fill=%0d err=%b want %0d/%b",
                     fill_cnt, err_flags, m_fill, m_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5);
            n_cmp++;
            if ({p_gnt, c_gnt, p_blk, c_blk, fill_cnt, blk_full, blk_empty, err_flags}
                !== {m_pg, m_cg, NB'(m_wp), NB'(m_rp), (NB+1)'(m_fill),
                     m_fill == N, m_fill == 0, m_err}) begin
                n_bad++;
                $display("FAIL random[%0d]: gnt=%b/%b blk=%0d/%0d fill=%0d err=%b want gnt=%b/%b blk=%0d/%0d fill=%0d err=%b",
                         i, p_gnt, c_gnt, p_blk, c_blk, fill_cnt, err_flags,
                         m_pg, m_cg, m_wp, m_rp, m_fill, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain_wrap();
        test_simul();
        test_errors();
        test_async_reset();
        test_wdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
